// File: rtl/inst_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_stage
//  Purpose  : Instruction-fetch stage of the 5-stage data-hazard CPU.
//             Owns the PC, drives the ROM byte address and captures the
//             returned word into the IF/ID pipeline register. Honours
//             load-use stalls and branch redirects with flush, and stops
//             fetching at the end of ROM space or on a halt request.
//  Ports    :
//    clk            in   1   clock, rising edge
//    rst            in   1   asynchronous active-high reset
//    stall          in   1   hold PC and IF/ID (load-use hazard)
//    branch_taken   in   1   redirect PC, flush IF/ID
//    branch_target  in  32   redirect byte address, bits [1:0] forced to 0
//    halt_req       in   1   stop fetching until reset
//    rom_addr       out 32   byte address to ROM (equals pc)
//    rom_inst       in  32   instruction word returned by ROM
//    if_id_inst     out 32   latched instruction
//    if_id_pc       out 32   byte address of if_id_inst
//    if_id_valid    out  1   if_id_inst is a real fetched instruction
//    halted         out  1   high while in HALT
//    fetch_count    out 16   valid instructions latched, saturating
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          ROM_WORDS = 64,
    parameter logic [31:0] NOP_INST  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    // First byte address past the end of ROM, and the last fetchable word.
    localparam logic [31:0] c_rom_limit = 32'(ROM_WORDS) << 2;
    localparam logic [31:0] c_last_pc   = c_rom_limit - 32'd4;
    localparam logic [15:0] c_count_max = 16'hFFFF;

    localparam logic [1:0] c_st_boot = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_inst;
    logic [31:0] r_if_id_pc;
    logic        r_if_id_valid;
    logic        r_halted;
    logic [15:0] r_fetch_count;

    logic [31:0] w_target;
    logic        w_target_oob;
    logic        w_at_end;

    // Target alignment masks the low bits rather than slicing them so every
    // bit of the port is consumed.
    assign w_target     = branch_target & ~32'd3;
    assign w_target_oob = (w_target >= c_rom_limit);
    // The last word is still fetched; the PC then parks instead of wrapping.
    assign w_at_end     = (r_pc >= c_last_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_boot;
            r_pc          <= PC_RESET;
            r_if_id_inst  <= NOP_INST;
            r_if_id_pc    <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= 16'd0;
        end else begin
            case (r_state)
                c_st_boot: begin
                    // One idle cycle so the ROM sees PC_RESET before the first latch.
                    r_state <= c_st_run;
                end

                c_st_run: begin
                    if (branch_taken) begin
                        // Branch beats stall: the stalled instruction is on the
                        // squashed path anyway.
                        r_if_id_inst  <= NOP_INST;
                        r_if_id_valid <= 1'b0;
                        if (w_target_oob) begin
                            r_state  <= c_st_halt;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_target;
                        end
                    end else if (halt_req) begin
                        r_if_id_inst  <= NOP_INST;
                        r_if_id_valid <= 1'b0;
                        r_state       <= c_st_halt;
                        r_halted      <= 1'b1;
                    end else if (stall) begin
                        // Everything holds.
                        r_state <= c_st_run;
                    end else begin
                        r_if_id_inst  <= rom_inst;
                        r_if_id_pc    <= r_pc;
                        r_if_id_valid <= 1'b1;
                        if (r_fetch_count != c_count_max) begin
                            r_fetch_count <= r_fetch_count + 16'd1;
                        end
                        if (w_at_end) begin
                            r_state  <= c_st_halt;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end
                end

                c_st_halt: begin
                    // Terminal: keep a bubble in IF/ID, ignore all requests.
                    r_if_id_inst  <= NOP_INST;
                    r_if_id_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end

                default: begin
                    r_state       <= c_st_halt;
                    r_if_id_inst  <= NOP_INST;
                    r_if_id_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
            endcase
        end
    end

    assign rom_addr    = r_pc;
    assign if_id_inst  = r_if_id_inst;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_stage
//  Purpose  : Self-checking bench for inst_fetch_stage with a behavioural
//             ROM and a queue of expected IF/ID contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_pc;
    logic [15:0] m_count;
    logic        m_halted;
    int          n_checks;
    int          n_pass;

    inst_fetch_stage #(
        .PC_RESET (32'h0000_0000),
        .ROM_WORDS(64),
        .NOP_INST (c_nop)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .if_id_inst   (if_id_inst),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {8'hC0, a[7:0] ^ 8'h5A, 8'h3C, a[7:0]};
    endfunction

    assign rom_inst = rom_word(rom_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        halt_req      = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        m_pc     = 32'd0;
        m_count  = 16'd0;
        m_halted = 1'b0;
        step();  // BOOT edge
    endtask

    // One uninterrupted fetch edge, checked against the scoreboard.
    task automatic advance(input string tag);
        exp_t e;
        e.pc   = m_pc;
        e.inst = rom_word(m_pc);
        sb_q.push_back(e);
        idle_inputs();
        step();
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (m_pc == 32'h0000_00FC) m_halted = 1'b1;
        else m_pc = m_pc + 32'd4;
        e = sb_q.pop_front();
        n_checks++;
        if (if_id_pc !== e.pc || if_id_inst !== e.inst || if_id_valid !== 1'b1)
            $display("FAIL %s ifid: got pc=%h inst=%h v=%b required pc=%h inst=%h v=1",
                     tag, if_id_pc, if_id_inst, if_id_valid, e.pc, e.inst);
        else n_pass++;
        n_checks++;
        if (fetch_count !== m_count || rom_addr !== m_pc || halted !== m_halted)
            $display("FAIL %s state: got cnt=%0d addr=%h halted=%b required cnt=%0d addr=%h halted=%b",
                     tag, fetch_count, rom_addr, halted, m_count, m_pc, m_halted);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        n_checks++;
        if (rom_addr !== 32'd0 || if_id_inst !== c_nop || if_id_pc !== 32'd0 ||
            if_id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0)
            $display("FAIL reset_values: got addr=%h inst=%h pc=%h v=%b h=%b cnt=%0d required all zero",
                     rom_addr, if_id_inst, if_id_pc, if_id_valid, halted, fetch_count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        m_pc = 32'd0; m_count = 16'd0; m_halted = 1'b0;
        step();
        n_checks++;
        if (if_id_valid !== 1'b0 || rom_addr !== 32'd0 || fetch_count !== 16'd0)
            $display("FAIL boot_edge: got v=%b addr=%h cnt=%0d required v=0 addr=0 cnt=0",
                     if_id_valid, rom_addr, fetch_count);
        else n_pass++;
    endtask

    task automatic test_sequential();
        advance("seq0");
        advance("seq4");
        advance("seq8");
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (rom_addr !== 32'h0C || if_id_pc !== 32'h08 || fetch_count !== m_count || if_id_valid !== 1'b1)
                $display("FAIL stall_hold%0d: got addr=%h pc=%h cnt=%0d v=%b required addr=0c pc=08 cnt=%0d v=1",
                         i, rom_addr, if_id_pc, fetch_count, if_id_valid, m_count);
            else n_pass++;
        end
        advance("stall_release");
    endtask

    task automatic test_branch();
        idle_inputs();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0013;
        step();
        idle_inputs();
        m_pc = 32'h10;
        n_checks++;
        if (rom_addr !== 32'h10 || if_id_valid !== 1'b0 || if_id_inst !== c_nop || fetch_count !== m_count)
            $display("FAIL branch_flush: got addr=%h v=%b inst=%h cnt=%0d required addr=10 v=0 inst=0 cnt=%0d",
                     rom_addr, if_id_valid, if_id_inst, fetch_count, m_count);
        else n_pass++;
        advance("branch_target_fetch");
    endtask

    task automatic test_branch_stall();
        idle_inputs();
        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h20;
        step();
        idle_inputs();
        m_pc = 32'h20;
        n_checks++;
        if (rom_addr !== 32'h20 || if_id_valid !== 1'b0 || fetch_count !== m_count)
            $display("FAIL branch_stall: got addr=%h v=%b cnt=%0d required addr=20 v=0 cnt=%0d",
                     rom_addr, if_id_valid, fetch_count, m_count);
        else n_pass++;
        advance("branch_stall_next");
    endtask

    task automatic test_end_of_rom();
        idle_inputs();
        branch_taken  = 1'b1;
        branch_target = 32'hF0;
        step();
        idle_inputs();
        m_pc = 32'hF0;
        advance("end_f0");
        advance("end_f4");
        advance("end_f8");
        advance("end_fc");
        // Requests during HALT must be ignored; IF/ID becomes a bubble.
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        halt_req      = 1'b1;
        stall         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (halted !== 1'b1 || rom_addr !== 32'hFC || if_id_valid !== 1'b0 ||
                if_id_inst !== c_nop || fetch_count !== m_count)
                $display("FAIL halt_hold%0d: got h=%b addr=%h v=%b inst=%h cnt=%0d required h=1 addr=fc v=0 inst=0 cnt=%0d",
                         i, halted, rom_addr, if_id_valid, if_id_inst, fetch_count, m_count);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_branch_oob();
        apply_reset();
        advance("oob_pre");
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        idle_inputs();
        n_checks++;
        if (halted !== 1'b1 || rom_addr !== 32'h04 || if_id_valid !== 1'b0 || fetch_count !== 16'd1)
            $display("FAIL branch_oob: got h=%b addr=%h v=%b cnt=%0d required h=1 addr=04 v=0 cnt=1",
                     halted, rom_addr, if_id_valid, fetch_count);
        else n_pass++;
    endtask

    task automatic test_halt_req();
        apply_reset();
        advance("hreq_pre0");
        advance("hreq_pre1");
        halt_req = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (halted !== 1'b1 || rom_addr !== 32'h08 || if_id_valid !== 1'b0 ||
            if_id_inst !== c_nop || fetch_count !== 16'd2)
            $display("FAIL halt_req: got h=%b addr=%h v=%b inst=%h cnt=%0d required h=1 addr=08 v=0 inst=0 cnt=2",
                     halted, rom_addr, if_id_valid, if_id_inst, fetch_count);
        else n_pass++;
        step();
        n_checks++;
        if (halted !== 1'b1 || rom_addr !== 32'h08)
            $display("FAIL halt_req_hold: got h=%b addr=%h required h=1 addr=08", halted, rom_addr);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        advance("ar_pre0");
        advance("ar_pre1");
        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        // Still before the next rising edge.
        n_checks++;
        if (rom_addr !== 32'd0 || if_id_inst !== c_nop || if_id_pc !== 32'd0 ||
            if_id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0)
            $display("FAIL async_reset: got addr=%h inst=%h pc=%h v=%b h=%b cnt=%0d required all zero",
                     rom_addr, if_id_inst, if_id_pc, if_id_valid, halted, fetch_count);
        else n_pass++;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        m_pc = 32'd0; m_count = 16'd0; m_halted = 1'b0;
        step();
        n_checks++;
        if (if_id_valid !== 1'b0 || rom_addr !== 32'd0)
            $display("FAIL async_reset_boot: got v=%b addr=%h required v=0 addr=0", if_id_valid, rom_addr);
        else n_pass++;
        advance("ar_restart0");
        advance("ar_restart4");
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle_inputs();
        m_pc = 32'd0; m_count = 16'd0; m_halted = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_stall();
        test_end_of_rom();
        test_branch_oob();
        test_halt_req();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
